// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one sequential multiplier between NUM_REQ clients.
// Latches the winner's operands, pulses start/reset_sync, waits for ready (with timeout), returns the product.
module mult_share_arbiter #(
  parameter int WORD_LENGTH = 4,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]   op_a,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]   op_b,
  output logic [NUM_REQ-1:0]               done,
  output logic [2*WORD_LENGTH-1:0]         result,
  output logic                             result_err,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy,
  output logic [WORD_LENGTH-1:0]           mul_a,
  output logic [WORD_LENGTH-1:0]           mul_b,
  output logic                             mul_start,
  output logic                             mul_reset_sync,
  input  logic [2*WORD_LENGTH-1:0]         mul_data_out,
  input  logic                             mul_ready
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Handshake: req is a level held by the client until its one-cycle done pulse;
  // the multiplier is started by a single mul_start cycle and answers with mul_ready.

  state_t                  state_q;
  logic [IDW-1:0]          last_q;
  logic [IDW-1:0]          grant_q;
  logic [WORD_LENGTH-1:0]  mul_a_q;
  logic [WORD_LENGTH-1:0]  mul_b_q;
  logic                    start_q;
  logic                    rsync_q;
  logic [CW-1:0]           cnt_q;
  logic [2*WORD_LENGTH-1:0] result_q;
  logic                    err_q;
  logic [NUM_REQ-1:0]      done_q;

  logic                    win_found_d;
  logic [IDW-1:0]          win_idx_d;
  logic [IDW-1:0]          cand_d;
  logic [WORD_LENGTH-1:0]  win_a_d;
  logic [WORD_LENGTH-1:0]  win_b_d;

  // Search starts just after the previous winner and wraps, so the last winner has lowest priority.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_d = IDW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found_d && req[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
    win_a_d = WORD_LENGTH'(op_a >> (int'(win_idx_d) * WORD_LENGTH));
    win_b_d = WORD_LENGTH'(op_b >> (int'(win_idx_d) * WORD_LENGTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(NUM_REQ - 1);
      grant_q  <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      start_q  <= 1'b0;
      rsync_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            mul_a_q <= win_a_d;
            mul_b_q <= win_b_d;
            grant_q <= win_idx_d;
            last_q  <= win_idx_d;
            start_q <= 1'b1;
            rsync_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          rsync_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Ready is checked first so a product arriving on the last allowed cycle is not flagged.
          if (mul_ready) begin
            result_q <= mul_data_out;
            err_q    <= 1'b0;
            done_q   <= NUM_REQ'(1) << grant_q;
            state_q  <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
            done_q   <= NUM_REQ'(1) << grant_q;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          done_q  <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done           = done_q;
  assign result         = result_q;
  assign result_err     = err_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != S_IDLE);
  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign mul_start      = start_q;
  assign mul_reset_sync = rsync_q;

endmodule
